// File: rtl/l2_pri_bank_arbiter.sv
// l2_pri_bank_arbiter
// Shares one private L2 SRAM bank TCDM slave port between NB_MASTERS requesters.
// One master (PRIO_IDX) has priority, limited by a starvation guard; the others are
// served round-robin. Responses return in order via a small owner-ID FIFO.
// Ports:
//   clk_i, rst_i (async, active-high)
//   m_req_i/m_add_i/m_wen_i/m_wdata_i/m_be_i : packed per-master request side
//   m_gnt_o, m_r_valid_o                     : one-hot or zero per master
//   m_r_rdata_o, m_r_opc_o                   : broadcast response data, error tied 0
//   s_req_o/s_add_o/s_wen_o/s_wdata_o/s_be_o : bank request side
//   s_gnt_i, s_r_valid_i, s_r_rdata_i        : bank grant and response
//   err_o                                    : sticky, response with nothing outstanding
module l2_pri_bank_arbiter #(
  parameter int unsigned NB_MASTERS    = 3,
  parameter int unsigned PRIO_IDX      = 0,
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter int unsigned ID_FIFO_DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NB_MASTERS-1:0]    m_req_i,
  input  logic [NB_MASTERS*32-1:0] m_add_i,
  input  logic [NB_MASTERS-1:0]    m_wen_i,
  input  logic [NB_MASTERS*32-1:0] m_wdata_i,
  input  logic [NB_MASTERS*4-1:0]  m_be_i,
  output logic [NB_MASTERS-1:0]    m_gnt_o,
  output logic [NB_MASTERS-1:0]    m_r_valid_o,
  output logic [31:0]              m_r_rdata_o,
  output logic                     m_r_opc_o,
  output logic                     s_req_o,
  output logic [31:0]              s_add_o,
  output logic                     s_wen_o,
  output logic [31:0]              s_wdata_o,
  output logic [3:0]               s_be_o,
  input  logic                     s_gnt_i,
  input  logic                     s_r_valid_i,
  input  logic [31:0]              s_r_rdata_i,
  output logic                     err_o
);

  localparam int unsigned IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam int unsigned PTR_W = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(ID_FIFO_DEPTH + 1);
  localparam int unsigned SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [SC_W-1:0]       StarveMax = SC_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]      FifoDepth = CNT_W'(ID_FIFO_DEPTH);
  localparam logic [PTR_W-1:0]      PtrLast   = PTR_W'(ID_FIFO_DEPTH - 1);
  localparam logic [IDX_W-1:0]      LastIdx   = IDX_W'(NB_MASTERS - 1);
  localparam logic [IDX_W-1:0]      PrioId    = IDX_W'(PRIO_IDX);
  localparam logic [NB_MASTERS-1:0] PrioMask  = NB_MASTERS'(1) << PRIO_IDX;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SC_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [IDX_W-1:0] fifo_q [ID_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             err_q, err_d;

  logic                  others_req, prio_win, rr_found;
  logic [NB_MASTERS-1:0] scan_req;
  logic [IDX_W-1:0]      rr_w, winner, head;
  logic                  fifo_full, fifo_empty, accept, pop;

  // Once the starvation guard trips, the priority master is dropped from the scan so a
  // waiting master is guaranteed the next slot; with STARVE_LIMIT==0 it is an ordinary
  // round-robin participant.
  always_comb begin
    int unsigned j;
    others_req = |(m_req_i & ~PrioMask);
    prio_win   = (STARVE_LIMIT != 0) && m_req_i[PRIO_IDX] && (starve_cnt_q < StarveMax);
    scan_req   = ((STARVE_LIMIT != 0) && others_req) ? (m_req_i & ~PrioMask) : m_req_i;
    rr_w       = rr_ptr_q;
    rr_found   = 1'b0;
    j          = 0;
    for (int k = 0; k < NB_MASTERS; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NB_MASTERS) j = j - NB_MASTERS;
      if (!rr_found && scan_req[j]) begin
        rr_found = 1'b1;
        rr_w     = IDX_W'(j);
      end
    end
    winner = prio_win ? PrioId : rr_w;
  end

  assign fifo_full  = (fifo_cnt_q == FifoDepth);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign s_req_o    = (|m_req_i) & ~fifo_full;
  assign accept     = s_req_o & s_gnt_i;
  assign pop        = s_r_valid_i & ~fifo_empty;
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    s_add_o   = m_add_i[31:0];
    s_wdata_o = m_wdata_i[31:0];
    s_be_o    = m_be_i[3:0];
    s_wen_o   = m_wen_i[0];
    for (int i = 0; i < NB_MASTERS; i++) begin
      m_gnt_o[i]     = accept && (winner == IDX_W'(i));
      m_r_valid_o[i] = pop && (head == IDX_W'(i));
      if (winner == IDX_W'(i)) begin
        s_add_o   = m_add_i[32*i +: 32];
        s_wdata_o = m_wdata_i[32*i +: 32];
        s_be_o    = m_be_i[4*i +: 4];
        s_wen_o   = m_wen_i[i];
      end
    end
  end

  assign m_r_rdata_o = s_r_rdata_i;
  assign m_r_opc_o   = 1'b0;
  assign err_o       = err_q;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_cnt_d   = fifo_cnt_q;
    err_d        = err_q | (s_r_valid_i & fifo_empty);
    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      if (!prio_win) rr_ptr_d = (winner == LastIdx) ? '0 : winner + 1'b1;
      if (winner == PrioId && others_req) begin
        if (starve_cnt_q != StarveMax) starve_cnt_d = starve_cnt_q + 1'b1;
      end else begin
        starve_cnt_d = '0;
      end
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    // Full already blocks accept, so the count can never overflow.
    unique case ({accept, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      starve_cnt_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < ID_FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      err_q        <= err_d;
      if (accept) fifo_q[wr_ptr_q] <= winner;
    end
  end

endmodule

// File: tb/tb_l2_pri_bank_arbiter.sv
// Directed bench for l2_pri_bank_arbiter with default parameters (3 masters, prio 0,
// starvation limit 4, ID FIFO depth 2). Expected values are hand-derived.
module tb_l2_pri_bank_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  m_req_i;
  logic [95:0] m_add_i;
  logic [2:0]  m_wen_i;
  logic [95:0] m_wdata_i;
  logic [11:0] m_be_i;
  logic [2:0]  m_gnt_o, m_r_valid_o;
  logic [31:0] m_r_rdata_o;
  logic        m_r_opc_o;
  logic        s_req_o;
  logic [31:0] s_add_o;
  logic        s_wen_o;
  logic [31:0] s_wdata_o;
  logic [3:0]  s_be_o;
  logic        s_gnt_i, s_r_valid_i;
  logic [31:0] s_r_rdata_i;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  l2_pri_bank_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .m_req_i     (m_req_i),
    .m_add_i     (m_add_i),
    .m_wen_i     (m_wen_i),
    .m_wdata_i   (m_wdata_i),
    .m_be_i      (m_be_i),
    .m_gnt_o     (m_gnt_o),
    .m_r_valid_o (m_r_valid_o),
    .m_r_rdata_o (m_r_rdata_o),
    .m_r_opc_o   (m_r_opc_o),
    .s_req_o     (s_req_o),
    .s_add_o     (s_add_o),
    .s_wen_o     (s_wen_o),
    .s_wdata_o   (s_wdata_o),
    .s_be_o      (s_be_o),
    .s_gnt_i     (s_gnt_i),
    .s_r_valid_i (s_r_valid_i),
    .s_r_rdata_i (s_r_rdata_i),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Short async reset pulse between clock edges.
  task automatic pulse_reset();
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
  endtask

  int          t3_order [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1};
  logic [2:0]  exp_g, prev_g;

  initial begin
    rst_i       = 1'b1;
    m_req_i     = '0;
    m_add_i     = {32'h1C02_0000, 32'h1C01_0000, 32'h1C00_0000};
    m_wdata_i   = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
    m_wen_i     = 3'b110;
    m_be_i      = {4'hC, 4'h3, 4'hF};
    s_gnt_i     = 1'b0;
    s_r_valid_i = 1'b0;
    s_r_rdata_i = '0;
    #2;
    check_eq("rst_s_req", 32'(s_req_o), 32'd0);
    check_eq("rst_gnt", 32'(m_gnt_o), 32'd0);
    check_eq("rst_rvalid", 32'(m_r_valid_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_opc", 32'(m_r_opc_o), 32'd0);
    #10;
    rst_i = 1'b0;
    cycle();

    // T1: single read from master 1
    m_req_i = 3'b010; s_gnt_i = 1'b1; #1;
    check_eq("t1_gnt", 32'(m_gnt_o), 32'h2);
    check_eq("t1_s_req", 32'(s_req_o), 32'd1);
    check_eq("t1_add", s_add_o, 32'h1C01_0000);
    check_eq("t1_wen", 32'(s_wen_o), 32'd1);
    check_eq("t1_be", 32'(s_be_o), 32'h3);
    check_eq("t1_wdata", s_wdata_o, 32'hC1C1_C1C1);
    cycle();
    m_req_i = '0; s_r_valid_i = 1'b1; s_r_rdata_i = 32'hDEAD_BEEF; #1;
    check_eq("t1_rvalid", 32'(m_r_valid_o), 32'h2);
    check_eq("t1_rdata", m_r_rdata_o, 32'hDEAD_BEEF);
    check_eq("t1_idle_s_req", 32'(s_req_o), 32'd0);
    cycle();
    s_r_valid_i = 1'b0; #1;
    check_eq("t1_err", 32'(err_o), 32'd0);

    // T2: masters 1 and 2 alternate, 1-cycle bank
    pulse_reset();
    m_req_i = 3'b110; s_gnt_i = 1'b1;
    prev_g = '0;
    for (int k = 0; k < 4; k++) begin
      exp_g       = (k % 2 == 0) ? 3'b010 : 3'b100;
      s_r_valid_i = (k > 0);
      s_r_rdata_i = 32'h2000 + k;
      #1;
      check_eq($sformatf("t2_gnt%0d", k), 32'(m_gnt_o), 32'(exp_g));
      check_eq($sformatf("t2_rv%0d", k), 32'(m_r_valid_o), 32'(prev_g));
      prev_g = exp_g;
      cycle();
    end
    m_req_i = '0; s_r_valid_i = 1'b1; #1;
    check_eq("t2_rv_last", 32'(m_r_valid_o), 32'h4);
    cycle();
    s_r_valid_i = 1'b0;

    // T3: all request, starvation guard interleaves masters 1 and 2
    pulse_reset();
    m_req_i = 3'b111; s_gnt_i = 1'b1;
    prev_g = '0;
    for (int k = 0; k < 15; k++) begin
      exp_g       = 3'b001 << t3_order[k];
      s_r_valid_i = (k > 0);
      #1;
      check_eq($sformatf("t3_gnt%0d", k), 32'(m_gnt_o), 32'(exp_g));
      check_eq($sformatf("t3_rv%0d", k), 32'(m_r_valid_o), 32'(prev_g));
      prev_g = exp_g;
      cycle();
    end
    m_req_i = '0; s_r_valid_i = 1'b1; #1;
    check_eq("t3_rv_last", 32'(m_r_valid_o), 32'h2);
    cycle();
    s_r_valid_i = 1'b0; #1;
    check_eq("t3_err", 32'(err_o), 32'd0);

    // T4: backpressure on a write from master 0, then exactly one push
    pulse_reset();
    m_req_i = 3'b001; s_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("t4_s_req%0d", k), 32'(s_req_o), 32'd1);
      check_eq($sformatf("t4_gnt%0d", k), 32'(m_gnt_o), 32'd0);
      cycle();
    end
    s_gnt_i = 1'b1; #1;
    check_eq("t4_gnt", 32'(m_gnt_o), 32'h1);
    check_eq("t4_wen", 32'(s_wen_o), 32'd0);
    check_eq("t4_wdata", s_wdata_o, 32'hC0C0_C0C0);
    cycle();
    m_req_i = '0; s_gnt_i = 1'b0; s_r_valid_i = 1'b1; #1;
    check_eq("t4_rv", 32'(m_r_valid_o), 32'h1);
    cycle();
    #1;
    check_eq("t4_rv_extra", 32'(m_r_valid_o), 32'h0);
    check_eq("t4_err_pre", 32'(err_o), 32'd0);
    cycle();
    s_r_valid_i = 1'b0; #1;
    check_eq("t4_err", 32'(err_o), 32'd1);

    // T5: FIFO full stalls grants until a response frees a slot
    pulse_reset();
    #1;
    check_eq("t5_err_cleared", 32'(err_o), 32'd0);
    m_req_i = 3'b110; s_gnt_i = 1'b1; #1;
    check_eq("t5_gnt0", 32'(m_gnt_o), 32'h2);
    cycle();
    check_eq("t5_gnt1", 32'(m_gnt_o), 32'h4);
    cycle();
    check_eq("t5_full_s_req", 32'(s_req_o), 32'd0);
    check_eq("t5_full_gnt", 32'(m_gnt_o), 32'd0);
    cycle();
    check_eq("t5_full_s_req2", 32'(s_req_o), 32'd0);
    s_r_valid_i = 1'b1; #1;
    check_eq("t5_pop_rv", 32'(m_r_valid_o), 32'h2);
    check_eq("t5_pop_gnt", 32'(m_gnt_o), 32'd0);
    cycle();
    s_r_valid_i = 1'b0; #1;
    check_eq("t5_regnt", 32'(m_gnt_o), 32'h2);
    cycle();
    m_req_i = '0; s_r_valid_i = 1'b1; #1;
    check_eq("t5_rv_a", 32'(m_r_valid_o), 32'h4);
    cycle();
    check_eq("t5_rv_b", 32'(m_r_valid_o), 32'h2);
    cycle();
    s_r_valid_i = 1'b0; #1;
    check_eq("t5_err", 32'(err_o), 32'd0);

    // T6: reset with one outstanding transfer, then a stray response
    pulse_reset();
    m_req_i = 3'b010; s_gnt_i = 1'b1; #1;
    check_eq("t6_gnt", 32'(m_gnt_o), 32'h2);
    cycle();
    m_req_i = '0;
    rst_i = 1'b1; #1;
    check_eq("t6_rst_gnt", 32'(m_gnt_o), 32'd0);
    rst_i = 1'b0;
    s_r_valid_i = 1'b1; #1;
    check_eq("t6_rv", 32'(m_r_valid_o), 32'd0);
    check_eq("t6_err_pre", 32'(err_o), 32'd0);
    cycle();
    s_r_valid_i = 1'b0; #1;
    check_eq("t6_err", 32'(err_o), 32'd1);
    cycle();
    cycle();
    check_eq("t6_err_sticky", 32'(err_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
